vga_vram_arbiter: RTL and testbench
===================================

# vga_vram_arbiter

Shares the single-port video RAM between the scan-out pixel fetcher and the 6502 register port of the VGA core. The 6502 side, already synchronised into the CLK_12M domain by the bus front end, writes and reads VRAM through an auto-incrementing address/data register pair. Writes are buffered in a 4-entry FIFO so the CPU never stalls the display. Display fetches have absolute priority; CPU traffic fills the idle RAM cycles.

## Interface
- ADDR_W, 15, VRAM address width
- FIFO_DEPTH, 4, CPU write buffer entries (power of two)
- CLK_12M  in  1  system clock, 12 MHz
- RST_N  in  1  reset, synchronous, active-low
- FETCH_REQ  in  1  display fetch request, held until FETCH_ACK
- FETCH_ADDR  in  15  display fetch address
- FETCH_ACK  out  1  one-cycle grant of the current request
- FETCH_DATA  out  8  fetched byte
- FETCH_VALID  out  1  one-cycle strobe, FETCH_DATA valid
- CPU_WR_STB  in  1  one-cycle register write strobe
- CPU_RD_STB  in  1  one-cycle register read strobe
- CPU_REG  in  3  register index
- CPU_WDATA  in  8  write data
- CPU_RDATA  out  8  read data, combinational mux on CPU_REG
- RAM_ADDR  out  15  RAM address, registered
- RAM_WDATA  out  8  RAM write data, registered
- RAM_WE  out  1  RAM write enable, registered
- RAM_RDATA  in  8  RAM read data, valid the cycle after the address is presented

## Operation
- Registers: 0 ADDR_LO; 1 ADDR_HI (bits 6:0, bit 7 reads 0); 2 DATA; 3 STATUS = {4'b0, OVF, RD_READY, EMPTY, FULL}; 4–7 read 0, writes ignored.
- ADDR_LO/ADDR_HI write: updates the 15-bit pointer, clears RD_READY, sets rd_pending.
- DATA write: enqueues {pointer, CPU_WDATA}, then pointer += 1 (wraps 0x7FFF→0x0000). When FIFO is FULL: entry dropped, pointer unchanged, OVF set (sticky).
- DATA read with RD_READY=1: returns RD_BUF, pointer += 1, RD_READY cleared, rd_pending set. With RD_READY=0: returns RD_BUF, no side effects.
- STATUS read clears OVF on the following cycle.
- CPU_WR_STB and CPU_RD_STB together: the write is performed, the read is ignored.
- Arbiter, one RAM access per cycle, fixed priority: FETCH > WR (FIFO non-empty) > RD (rd_pending and FIFO empty). RD waits for the FIFO to drain, so reads always see prior writes.
- Grant states: G_NONE, G_FETCH, G_WR, G_RD. The state is re-evaluated every cycle with no hold-over, so back-to-back grants are allowed.
- Reset: all outputs 0, FIFO empty, pointer 0, RD_BUF 0, RD_READY/rd_pending/OVF 0, grant G_NONE. An in-flight read is discarded; no FETCH_VALID or RD_READY results from it.

## Timing
- Fetch: FETCH_REQ sampled at edge E. FETCH_ACK, RAM_ADDR and G_FETCH are valid in cycle E+1. RAM_RDATA is valid in cycle E+2. FETCH_DATA and FETCH_VALID are valid in cycle E+3. Latency is 3 cycles.
- The requester may present the next address in the cycle after FETCH_ACK. A continuous FETCH_REQ yields one fetch per cycle and fully starves the CPU. The display fetcher guarantees idle cycles in blanking.
- WR: the FIFO head is popped at the grant edge. RAM_WE is high for exactly one cycle.
- RD: RD_BUF is loaded and RD_READY set 2 cycles after the grant edge. A pointer write during an in-flight RD discards that result and restarts the prefetch.
- FIFO: push and pop in the same cycle are both legal, and the count is unchanged. Push while FULL with a simultaneous pop is accepted.

## Structure
- Shared package vga_pkg: register indices (REG_ADDR_LO..REG_STATUS), STATUS bit positions, ADDR_W, grant enum.
- Sub-module vga_wr_fifo: FIFO_DEPTH × 23-bit synchronous FIFO with full/empty, same clock and reset.

## Test plan
- Reset mid-fetch: assert RST_N=0 the cycle after FETCH_ACK → no FETCH_VALID; all outputs 0 the next cycle.
- Fetch latency: FETCH_REQ with FETCH_ADDR=0x1234, RAM model returning 0xA5 → FETCH_ACK at +1, RAM_ADDR=0x1234 at +1, FETCH_DATA=0xA5 with FETCH_VALID at +3.
- CPU write burst: ADDR_HI=0x7F, ADDR_LO=0xFE, DATA writes 0x11, 0x22, 0x33 with FETCH_REQ held low → RAM writes to 0x7FFE, 0x7FFF, 0x0000 in order; final pointer 0x0001.
- Overflow under a fetch storm: FETCH_REQ held high, 5 DATA writes → FULL=1, 5th dropped, OVF=1. Release FETCH_REQ → 4 RAM writes. STATUS read returns OVF=1, and the next STATUS read returns OVF=0.
- Read-after-write: write 0x5A to 0x0100, rewrite the pointer to 0x0100 → the RD is issued only after the WR completes. RD_READY=1, DATA read returns 0x5A, pointer becomes 0x0101.
- Simultaneous strobes: CPU_WR_STB and CPU_RD_STB on REG 2 together → one FIFO push; pointer advances once; RD_READY unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA core: CPU register map, STATUS bit layout,
// VRAM geometry and the VRAM arbiter grant encoding.
package vga_pkg;

  localparam int ADDR_W = 15;

  localparam logic [2:0] REG_ADDR_LO = 3'd0;
  localparam logic [2:0] REG_ADDR_HI = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_RD_READY = 2;
  localparam int STAT_OVF      = 3;

  typedef enum logic [1:0] {
    G_NONE,
    G_FETCH,
    G_WR,
    G_RD
  } grant_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO buffering CPU writes ({address, data}) until the
// arbiter finds an idle VRAM cycle. DEPTH must be a power of two.
module vga_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, buffered CPU writes
// and the CPU read prefetch fill the remaining RAM cycles.
module vga_vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK_12M,
  input  logic              RST_N,
  input  logic              FETCH_REQ,
  input  logic [ADDR_W-1:0] FETCH_ADDR,
  output logic              FETCH_ACK,
  output logic [7:0]        FETCH_DATA,
  output logic              FETCH_VALID,
  input  logic              CPU_WR_STB,
  input  logic              CPU_RD_STB,
  input  logic [2:0]        CPU_REG,
  input  logic [7:0]        CPU_WDATA,
  output logic [7:0]        CPU_RDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [7:0]        RAM_WDATA,
  output logic              RAM_WE,
  input  logic [7:0]        RAM_RDATA
);

  import vga_pkg::*;

  localparam int ENTRY_W = ADDR_W + 8;

  grant_t             grant;
  grant_t             next_grant;
  logic [ADDR_W-1:0]  ptr;
  logic [7:0]         rd_buf;
  logic               rd_ready;
  logic               rd_pending;
  logic               ovf;
  logic               fetch_d1;
  logic               rd_d1;
  logic               wr_cycle;
  logic               rd_cycle;
  logic               addr_wr;
  logic               data_wr;
  logic               data_rd;
  logic               status_rd;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [7:0]         status;

  // A simultaneous read strobe is dropped so the write alone takes effect.
  assign wr_cycle  = CPU_WR_STB;
  assign rd_cycle  = CPU_RD_STB && !CPU_WR_STB;
  assign addr_wr   = wr_cycle && (CPU_REG == REG_ADDR_LO || CPU_REG == REG_ADDR_HI);
  assign data_wr   = wr_cycle && (CPU_REG == REG_DATA);
  assign data_rd   = rd_cycle && (CPU_REG == REG_DATA) && rd_ready;
  assign status_rd = rd_cycle && (CPU_REG == REG_STATUS);
  assign fifo_pop  = (next_grant == G_WR);
  assign fifo_push = data_wr && (!fifo_full || fifo_pop);

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk   (CLK_12M),
    .rst_n (RST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({ptr, CPU_WDATA}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The prefetch is also held off while the CPU is pushing a write or moving
  // the pointer, otherwise it could return a byte that is about to change.
  always_comb begin
    next_grant = G_NONE;
    if (FETCH_REQ)
      next_grant = G_FETCH;
    else if (!fifo_empty)
      next_grant = G_WR;
    else if (rd_pending && !data_wr && !addr_wr)
      next_grant = G_RD;
  end

  always_ff @(posedge CLK_12M) begin
    if (!RST_N) grant <= G_NONE;
    else        grant <= next_grant;
  end

  always_ff @(posedge CLK_12M) begin
    if (!RST_N) begin
      FETCH_ACK   <= 1'b0;
      FETCH_DATA  <= '0;
      FETCH_VALID <= 1'b0;
      RAM_ADDR    <= '0;
      RAM_WDATA   <= '0;
      RAM_WE      <= 1'b0;
      fetch_d1    <= 1'b0;
    end else begin
      FETCH_ACK <= (next_grant == G_FETCH);
      RAM_WE    <= (next_grant == G_WR);
      case (next_grant)
        G_FETCH: RAM_ADDR <= FETCH_ADDR;
        G_WR: begin
          RAM_ADDR  <= fifo_head[ENTRY_W-1:8];
          RAM_WDATA <= fifo_head[7:0];
        end
        G_RD:    RAM_ADDR <= ptr;
        default: ;
      endcase
      fetch_d1    <= (grant == G_FETCH);
      FETCH_VALID <= fetch_d1;
      if (fetch_d1) FETCH_DATA <= RAM_RDATA;
    end
  end

  // A pointer write kills any prefetch still in the RAM pipeline and restarts it.
  always_ff @(posedge CLK_12M) begin
    if (!RST_N) begin
      ptr        <= '0;
      rd_buf     <= '0;
      rd_ready   <= 1'b0;
      rd_pending <= 1'b0;
      ovf        <= 1'b0;
      rd_d1      <= 1'b0;
    end else begin
      rd_d1 <= (grant == G_RD) && !addr_wr;
      if (next_grant == G_RD) rd_pending <= 1'b0;
      if (rd_d1 && !addr_wr) begin
        rd_buf   <= RAM_RDATA;
        rd_ready <= 1'b1;
      end
      if (status_rd)             ovf <= 1'b0;
      if (data_wr && !fifo_push) ovf <= 1'b1;
      if (addr_wr) begin
        if (CPU_REG == REG_ADDR_LO) ptr[7:0]        <= CPU_WDATA;
        else                        ptr[ADDR_W-1:8] <= CPU_WDATA[ADDR_W-9:0];
        rd_ready   <= 1'b0;
        rd_pending <= 1'b1;
      end else if (fifo_push) begin
        ptr <= ptr + 1'b1;
      end else if (data_rd) begin
        ptr        <= ptr + 1'b1;
        rd_ready   <= 1'b0;
        rd_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_FULL]     = fifo_full;
    status[STAT_EMPTY]    = fifo_empty;
    status[STAT_RD_READY] = rd_ready;
    status[STAT_OVF]      = ovf;
    CPU_RDATA             = '0;
    case (CPU_REG)
      REG_ADDR_LO: CPU_RDATA = ptr[7:0];
      REG_ADDR_HI: CPU_RDATA = 8'(ptr[ADDR_W-1:8]);
      REG_DATA:    CPU_RDATA = rd_buf;
      REG_STATUS:  CPU_RDATA = status;
      default:     CPU_RDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: a register-map vector table plus
// hand-written fetch, reset, write-burst, overflow and read-after-write sequences.
module tb_vga_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [14:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        fetch_valid;
  logic        cpu_wr_stb;
  logic        cpu_rd_stb;
  logic [2:0]  cpu_reg;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:32767];
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [7:0]  pre_data;
  logic [14:0] log_addr [$];
  logic [7:0]  log_data [$];

  typedef struct {
    bit         wr;
    bit         rd;
    logic [2:0] regi;
    logic [7:0] wdata;
    bit         chk;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [14];

  vga_vram_arbiter #(
    .ADDR_W     (15),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_12M     (clk),
    .RST_N       (rst_n),
    .FETCH_REQ   (fetch_req),
    .FETCH_ADDR  (fetch_addr),
    .FETCH_ACK   (fetch_ack),
    .FETCH_DATA  (fetch_data),
    .FETCH_VALID (fetch_valid),
    .CPU_WR_STB  (cpu_wr_stb),
    .CPU_RD_STB  (cpu_rd_stb),
    .CPU_REG     (cpu_reg),
    .CPU_WDATA   (cpu_wdata),
    .CPU_RDATA   (cpu_rdata),
    .RAM_ADDR    (ram_addr),
    .RAM_WDATA   (ram_wdata),
    .RAM_WE      (ram_we),
    .RAM_RDATA   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM model, one-cycle read latency, logs every write.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_wdata);
    end
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [2:0] regi, input logic [7:0] wdata);
    cpu_wr_stb = wr;
    cpu_rd_stb = rd;
    cpu_reg    = regi;
    cpu_wdata  = wdata;
  endtask

  task automatic cpuWrite(input logic [2:0] regi, input logic [7:0] wdata);
    applyStimulus(1'b1, 1'b0, regi, wdata);
    tick();
    applyStimulus(1'b0, 1'b0, regi, 8'h00);
  endtask

  task automatic cpuRead(input logic [2:0] regi, input string name, input logic [7:0] exp);
    applyStimulus(1'b0, 1'b1, regi, 8'h00);
    #1;
    checkOutput(name, {8'h00, cpu_rdata}, {8'h00, exp});
    tick();
    applyStimulus(1'b0, 1'b0, regi, 8'h00);
  endtask

  task automatic peek(input logic [2:0] regi, input string name, input logic [7:0] exp);
    cpu_reg = regi;
    #1;
    checkOutput(name, {8'h00, cpu_rdata}, {8'h00, exp});
  endtask

  task automatic checkWrite(input int idx, input string name, input logic [14:0] ea, input logic [7:0] ed);
    logic [15:0] got_a;
    logic [15:0] got_d;
    got_a = 16'hFFFF;
    got_d = 16'hFFFF;
    if (idx < log_addr.size()) begin
      got_a = {1'b0, log_addr[idx]};
      got_d = {8'h00, log_data[idx]};
    end
    checkOutput({name, "_addr"}, got_a, {1'b0, ea});
    checkOutput({name, "_data"}, got_d, {8'h00, ed});
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  initial begin
    int base;
    int waited;
    logic [14:0] burst_a [3];
    logic [7:0]  burst_d [3];

    vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'h34, 1'b0, 8'h00, "addr_lo_wr"};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 8'hFF, 1'b0, 8'h00, "addr_hi_wr"};
    vecs[2]  = '{1'b0, 1'b1, 3'd1, 8'h00, 1'b1, 8'h7F, "addr_hi_bit7_zero"};
    vecs[3]  = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h34, "addr_lo_rd"};
    vecs[4]  = '{1'b1, 1'b0, 3'd5, 8'h99, 1'b0, 8'h00, "reg5_wr"};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b1, 8'h00, "reg5_rd"};
    vecs[6]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b1, 8'h00, "reg4_rd"};
    vecs[7]  = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b1, 8'h00, "reg7_rd"};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h34, "addr_lo_after_reg5"};
    vecs[9]  = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 8'h06, "status_rd_ready"};
    vecs[10] = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 8'hC7, "data_rd_prefetch"};
    vecs[11] = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h35, "ptr_inc_after_rd"};
    vecs[12] = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 8'hC7, "data_rd_not_ready"};
    vecs[13] = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 8'h35, "ptr_hold_not_ready"};

    rst_n      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    pre_we     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
    tick();
    preload(15'h1234, 8'hA5);
    preload(15'h0042, 8'h3C);
    preload(15'h7F34, 8'hC7);
    preload(15'h7F35, 8'h5E);
    preload(15'h0100, 8'hEE);
    tick();

    // Reset state
    checkOutput("rst_fetch_ack", {15'h0, fetch_ack}, 16'h0);
    checkOutput("rst_fetch_valid", {15'h0, fetch_valid}, 16'h0);
    checkOutput("rst_fetch_data", {8'h0, fetch_data}, 16'h0);
    checkOutput("rst_ram_addr", {1'b0, ram_addr}, 16'h0);
    checkOutput("rst_ram_wdata", {8'h0, ram_wdata}, 16'h0);
    checkOutput("rst_ram_we", {15'h0, ram_we}, 16'h0);
    peek(3'd0, "rst_ptr_lo", 8'h00);
    peek(3'd3, "rst_status", 8'h02);
    rst_n = 1'b1;
    tick();

    // Register map table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].regi, vecs[i].wdata);
      #1;
      if (vecs[i].chk) checkOutput(vecs[i].name, {8'h00, cpu_rdata}, {8'h00, vecs[i].exp});
      tick();
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
    idle(4);

    // Fetch latency
    fetch_req  = 1'b1;
    fetch_addr = 15'h1234;
    tick();
    checkOutput("fetch_ack_e1", {15'h0, fetch_ack}, 16'h1);
    checkOutput("fetch_ram_addr_e1", {1'b0, ram_addr}, 16'h1234);
    fetch_req = 1'b0;
    tick();
    checkOutput("fetch_ack_e2", {15'h0, fetch_ack}, 16'h0);
    checkOutput("fetch_valid_e2", {15'h0, fetch_valid}, 16'h0);
    tick();
    checkOutput("fetch_valid_e3", {15'h0, fetch_valid}, 16'h1);
    checkOutput("fetch_data_e3", {8'h0, fetch_data}, 16'h00A5);
    tick();
    checkOutput("fetch_valid_e4", {15'h0, fetch_valid}, 16'h0);

    // Reset in the cycle after FETCH_ACK
    fetch_req  = 1'b1;
    fetch_addr = 15'h0042;
    tick();
    checkOutput("mid_fetch_ack", {15'h0, fetch_ack}, 16'h1);
    fetch_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_fetch_valid", {15'h0, fetch_valid}, 16'h0);
    checkOutput("mid_rst_fetch_data", {8'h0, fetch_data}, 16'h0);
    checkOutput("mid_rst_ram_addr", {1'b0, ram_addr}, 16'h0);
    checkOutput("mid_rst_ptr", {8'h0, cpu_rdata}, 16'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_fetch_valid", {15'h0, fetch_valid}, 16'h0);
    tick();
    checkOutput("post_rst_fetch_valid2", {15'h0, fetch_valid}, 16'h0);

    // CPU write burst across the address wrap
    base = log_addr.size();
    cpuWrite(3'd1, 8'h7F);
    cpuWrite(3'd0, 8'hFE);
    cpuWrite(3'd2, 8'h11);
    cpuWrite(3'd2, 8'h22);
    cpuWrite(3'd2, 8'h33);
    idle(8);
    burst_a[0] = 15'h7FFE; burst_d[0] = 8'h11;
    burst_a[1] = 15'h7FFF; burst_d[1] = 8'h22;
    burst_a[2] = 15'h0000; burst_d[2] = 8'h33;
    checkOutput("burst_count", 16'(log_addr.size() - base), 16'd3);
    for (int i = 0; i < 3; i++) checkWrite(base + i, $sformatf("burst_wr%0d", i), burst_a[i], burst_d[i]);
    peek(3'd0, "burst_ptr_lo", 8'h01);
    peek(3'd1, "burst_ptr_hi", 8'h00);

    // Overflow while fetches starve the CPU
    cpuWrite(3'd0, 8'h00);
    cpuWrite(3'd1, 8'h10);
    fetch_req  = 1'b1;
    fetch_addr = 15'h0042;
    tick();
    tick();
    base = log_addr.size();
    for (int i = 0; i < 4; i++) cpuWrite(3'd2, 8'hA0 + 8'(i));
    peek(3'd3, "storm_status_full", 8'h01);
    cpuWrite(3'd2, 8'hA4);
    peek(3'd3, "storm_status_ovf", 8'h09);
    peek(3'd0, "storm_ptr_after_drop", 8'h04);
    checkOutput("storm_fetch_valid", {15'h0, fetch_valid}, 16'h1);
    checkOutput("storm_no_writes", 16'(log_addr.size() - base), 16'd0);
    fetch_req = 1'b0;
    idle(12);
    checkOutput("drain_count", 16'(log_addr.size() - base), 16'd4);
    for (int i = 0; i < 4; i++)
      checkWrite(base + i, $sformatf("drain_wr%0d", i), 15'h1000 + 15'(i), 8'hA0 + 8'(i));
    cpuRead(3'd3, "status_ovf_sticky", 8'h0E);
    cpuRead(3'd3, "status_ovf_cleared", 8'h06);

    // Read after write: prefetch must wait for the buffered write
    base = log_addr.size();
    cpuWrite(3'd1, 8'h01);
    cpuWrite(3'd0, 8'h00);
    cpuWrite(3'd2, 8'h5A);
    cpuWrite(3'd0, 8'h00);
    cpu_reg = 3'd3;
    #1;
    waited = 0;
    while (cpu_rdata[2] !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("raw_rd_ready_in_time", {15'h0, (waited < 20)}, 16'h1);
    checkOutput("raw_write_count", 16'(log_addr.size() - base), 16'd1);
    checkWrite(base, "raw_wr", 15'h0100, 8'h5A);
    cpuRead(3'd2, "raw_data", 8'h5A);
    peek(3'd0, "raw_ptr_lo", 8'h01);
    peek(3'd1, "raw_ptr_hi", 8'h01);
    peek(3'd3, "raw_rd_ready_cleared", 8'h02);

    // Simultaneous write and read strobes on DATA
    idle(6);
    peek(3'd3, "simul_pre_status", 8'h06);
    base = log_addr.size();
    applyStimulus(1'b1, 1'b1, 3'd2, 8'h77);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd2, 8'h00);
    peek(3'd3, "simul_status", 8'h04);
    peek(3'd0, "simul_ptr_lo", 8'h02);
    idle(6);
    checkOutput("simul_write_count", 16'(log_addr.size() - base), 16'd1);
    checkWrite(base, "simul_wr", 15'h0101, 8'h77);
    peek(3'd3, "simul_post_status", 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
